// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: a single-clock FIFO with registered read data, an
// occupancy count, almost-full/almost-empty thresholds and overflow/underflow
// reporting. Depth is 2**ADDRESS_SIZE. A read and a write can complete in the
// same cycle, including when the FIFO is full.
//
// Optional feature: define SYNC_FIFO_STICKY_ERR_EN to make overflow_o and
// underflow_o sticky. They then hold until err_clr_i or rst. Without the macro
// they are one-cycle pulses and err_clr_i is ignored.
module sync_fifo_flags #(
    parameter int DATA_WIDTH   = 8,
    parameter int ADDRESS_SIZE = 3,
    parameter int AF_LEVEL     = (1 << ADDRESS_SIZE) - 2,
    parameter int AE_LEVEL     = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    input  logic                    rd_en_i,
    input  logic                    err_clr_i,
    output logic [DATA_WIDTH-1:0]   data_o,
    output logic                    valid_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o,
    output logic [ADDRESS_SIZE:0]   count_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int DEPTH = 1 << ADDRESS_SIZE;
    localparam logic [ADDRESS_SIZE:0] DEPTH_CNT = DEPTH[ADDRESS_SIZE:0];
    localparam logic [ADDRESS_SIZE:0] AF_CNT    = AF_LEVEL[ADDRESS_SIZE:0];
    localparam logic [ADDRESS_SIZE:0] AE_CNT    = AE_LEVEL[ADDRESS_SIZE:0];

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [ADDRESS_SIZE-1:0] wr_ptr;
    logic [ADDRESS_SIZE-1:0] rd_ptr;
    logic [ADDRESS_SIZE:0]   count;
    logic                    rd_acc;
    logic                    wr_acc;
    logic                    ovf_evt;
    logic                    unf_evt;

    // Accept decisions depend only on the registered flags, so there is no
    // combinational path from the requests to any output.
    always_comb begin
        rd_acc  = rd_en_i && !empty_o;
        wr_acc  = wr_en_i && (!full_o || rd_acc);
        ovf_evt = wr_en_i && full_o && !rd_acc;
        unf_evt = rd_en_i && empty_o;
    end

    // Flags decode straight from the count register.
    always_comb begin
        count_o        = count;
        full_o         = (count == DEPTH_CNT);
        empty_o        = (count == '0);
        almost_full_o  = (count >= AF_CNT);
        almost_empty_o = (count <= AE_CNT);
    end

    // Storage array; deliberately not reset. A write to a full FIFO that is
    // also being read hits the slot being read, which returns its old word.
    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= data_i;
        end
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{ADDRESS_SIZE{1'b0}}, wr_acc}
                           - {{ADDRESS_SIZE{1'b0}}, rd_acc};
        end
    end

    // Registered read data; data_o holds its value between accepted reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= rd_acc;
            if (rd_acc) data_o <= mem[rd_ptr];
        end
    end

`ifdef SYNC_FIFO_STICKY_ERR_EN
    // Sticky error flags: a new error wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            if (ovf_evt)        overflow_o  <= 1'b1;
            else if (err_clr_i) overflow_o  <= 1'b0;
            if (unf_evt)        underflow_o <= 1'b1;
            else if (err_clr_i) underflow_o <= 1'b0;
        end
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr_i;

    // Single-cycle error pulses, one per rejected request.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_o  <= 1'b0;
            underflow_o <= 1'b0;
        end else begin
            overflow_o  <= ovf_evt;
            underflow_o <= unf_evt;
        end
    end
`endif

endmodule
